// File: rtl/seq_detector_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared types and helpers for the parametrised serial
//                sequence detector: FSM state encoding, fill-counter width
//                helper and legal-range checks for the block parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    localparam int c_w_min     = 2;
    localparam int c_w_max     = 16;
    localparam int c_cnt_w_min = 1;
    localparam int c_cnt_w_max = 16;

    // The fill counter must hold 0..W inclusive.
    function automatic int fill_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic bit w_legal(input int w);
        return (w >= c_w_min) && (w <= c_w_max);
    endfunction

    function automatic bit cnt_w_legal(input int cnt_w);
        return (cnt_w >= c_cnt_w_min) && (cnt_w <= c_cnt_w_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param_if
//  Description : Bundle of the detector's data, control and status signals.
//                master : stream/control source (drives x, pattern, clears)
//                slave  : the detector (drives match, match_cnt, cnt_sat)
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             x_valid;
    logic             x;
    logic             pat_load;
    logic [W-1:0]     pat_in;
    logic [W-1:0]     mask_in;
    logic             clr_cnt;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output x_valid, x, pat_load, pat_in, mask_in, clr_cnt,
        input  match, match_cnt, cnt_sat
    );

    modport slave (
        input  x_valid, x, pat_load, pat_in, mask_in, clr_cnt,
        output match, match_cnt, cnt_sat
    );

endinterface
`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating event counter with sticky saturation flag.
//                clk/rst : clock, asynchronous active-high reset
//                inc     : count one event
//                clr     : synchronous clear; a coincident inc still counts
//                count   : current count, holds at all-ones
//                sat     : set when count reaches all-ones, cleared by clr/rst
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] c_max = '1;
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (clr) begin
            // Clear first, then apply the coincident event.
            r_count <= inc ? c_one : '0;
            r_sat   <= inc && (c_one == c_max);
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
            if ((r_count + c_one) == c_max) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Serial sequence detector. Shifts accepted bits into a W-bit
//                history and compares it against a loadable pattern with a
//                per-bit care mask once W bits have been collected.
//                clk/rst : clock, asynchronous active-high reset
//                bus     : slave side of seq_detector_param_if
//                          (x_valid/x stream, pat_load/pat_in/mask_in,
//                           clr_cnt, match pulse, match_cnt, cnt_sat)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int W       = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);

    localparam int             c_fw   = fill_width(W);
    localparam logic [c_fw-1:0] c_full = c_fw'(W);
    localparam logic [c_fw-1:0] c_one  = c_fw'(1);

    if (!w_legal(W)) begin : g_bad_w
        $error("seq_detector_param: W out of range 2..16");
    end
    if (!cnt_w_legal(CNT_W)) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W out of range 1..16");
    end

    logic [W-1:0]     r_h;
    logic [W-1:0]     r_pat;
    logic [W-1:0]     r_mask;
    logic [c_fw-1:0]  r_fill;
    state_t           r_state;
    logic             r_match;

    logic             w_accept;
    logic [W-1:0]     w_h_next;
    logic [c_fw-1:0]  w_fill_next;
    logic             w_hit;
    logic [CNT_W-1:0] w_count;
    logic             w_sat;

    always_comb begin
        // A pattern load on the same edge discards the incoming bit.
        w_accept    = bus.x_valid & ~bus.pat_load;
        w_h_next    = {r_h[W-2:0], bus.x};
        w_fill_next = (r_state == ARMED) ? c_full : (r_fill + c_one);
        w_hit       = w_accept && (w_fill_next == c_full) &&
                      (((w_h_next ^ r_pat) & r_mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h     <= '0;
            r_pat   <= '0;
            r_mask  <= '1;
            r_fill  <= '0;
            r_state <= EMPTY;
            r_match <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (bus.pat_load) begin
                r_pat   <= bus.pat_in;
                r_mask  <= bus.mask_in;
                r_h     <= '0;
                r_fill  <= '0;
                r_state <= EMPTY;
            end else if (bus.x_valid) begin
                r_h     <= w_h_next;
                r_match <= w_hit;
                if (w_hit && (OVERLAP == 0)) begin
                    // Non-overlapping: the next match needs W fresh bits.
                    r_fill  <= '0;
                    r_state <= EMPTY;
                end else begin
                    r_fill  <= w_fill_next;
                    r_state <= (w_fill_next == c_full) ? ARMED : FILLING;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit),
        .clr   (bus.clr_cnt),
        .count (w_count),
        .sat   (w_sat)
    );

    assign bus.match     = r_match;
    assign bus.match_cnt = w_count;
    assign bus.cnt_sat   = w_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Directed bench for seq_detector_param. Three instances share
//                one stimulus stream:
//                  a : W=4 CNT_W=8 OVERLAP=1
//                  b : W=4 CNT_W=8 OVERLAP=0
//                  c : W=4 CNT_W=2 OVERLAP=1
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_valid = 1'b0;
    logic       x = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic [3:0] mask_in = 4'b0000;
    logic       clr_cnt = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.W(4), .CNT_W(8)) if_a ();
    seq_detector_param_if #(.W(4), .CNT_W(8)) if_b ();
    seq_detector_param_if #(.W(4), .CNT_W(2)) if_c ();

    assign if_a.x_valid = x_valid;  assign if_b.x_valid = x_valid;  assign if_c.x_valid = x_valid;
    assign if_a.x = x;              assign if_b.x = x;              assign if_c.x = x;
    assign if_a.pat_load = pat_load; assign if_b.pat_load = pat_load; assign if_c.pat_load = pat_load;
    assign if_a.pat_in = pat_in;    assign if_b.pat_in = pat_in;    assign if_c.pat_in = pat_in;
    assign if_a.mask_in = mask_in;  assign if_b.mask_in = mask_in;  assign if_c.mask_in = mask_in;
    assign if_a.clr_cnt = clr_cnt;  assign if_b.clr_cnt = clr_cnt;  assign if_c.clr_cnt = clr_cnt;

    seq_detector_param #(.W(4), .CNT_W(8), .OVERLAP(1)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_detector_param #(.W(4), .CNT_W(8), .OVERLAP(0)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    seq_detector_param #(.W(4), .CNT_W(2), .OVERLAP(1)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge; return 1 time unit after the
    // following rising edge so outputs can be sampled.
    task automatic cyc(input logic v, input logic b, input logic pl, input logic cc);
        @(negedge clk);
        x_valid  = v;
        x        = b;
        pat_load = pl;
        clr_cnt  = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] p, input logic [3:0] m);
        pat_in  = p;
        mask_in = m;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Send n bits (bits[n-1] first); e* give the expected match per bit,
    // also first-bit-at-index n-1.
    task automatic run_bits(input string tag, input int n, input logic [15:0] bits,
                            input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1'b1, bits[i], 1'b0, 1'b0);
            chk($sformatf("%s_a_bit%0d", tag, n - i), 32'(if_a.match), 32'(ea[i]));
            chk($sformatf("%s_b_bit%0d", tag, n - i), 32'(if_b.match), 32'(eb[i]));
            chk($sformatf("%s_c_bit%0d", tag, n - i), 32'(if_c.match), 32'(ec[i]));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", 32'(if_a.match), 32'd0);
        chk("rst_cnt", 32'(if_a.match_cnt), 32'd0);
        chk("rst_sat", 32'(if_c.cnt_sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Exact pattern, overlapping vs non-overlapping
        load(4'b1011, 4'b1111);
        run_bits("t1", 7, 16'b1011011, 16'b0001001, 16'b0001000, 16'b0001001);
        chk("t1_a_cnt", 32'(if_a.match_cnt), 32'd2);
        chk("t1_b_cnt", 32'(if_b.match_cnt), 32'd1);
        chk("t1_c_cnt", 32'(if_c.match_cnt), 32'd2);
        chk("t1_c_sat", 32'(if_c.cnt_sat), 32'd0);

        // Partial mask; c saturates at 3
        load(4'b1001, 4'b1001);
        run_bits("t3", 6, 16'b111101, 16'b000101, 16'b000100, 16'b000101);
        chk("t3_a_cnt", 32'(if_a.match_cnt), 32'd4);
        chk("t3_b_cnt", 32'(if_b.match_cnt), 32'd2);
        chk("t3_c_cnt", 32'(if_c.match_cnt), 32'd3);
        chk("t3_c_sat", 32'(if_c.cnt_sat), 32'd1);

        // Clear counters
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_a_cnt", 32'(if_a.match_cnt), 32'd0);
        chk("clr_c_cnt", 32'(if_c.match_cnt), 32'd0);
        chk("clr_c_sat", 32'(if_c.cnt_sat), 32'd0);

        // Mask all don't-care
        load(4'b0000, 4'b0000);
        run_bits("t4", 6, 16'b101010, 16'b000111, 16'b000100, 16'b000111);
        chk("t4_c_cnt", 32'(if_c.match_cnt), 32'd3);
        chk("t4_c_sat", 32'(if_c.cnt_sat), 32'd1);
        chk("t4_a_cnt", 32'(if_a.match_cnt), 32'd3);
        // clr_cnt coincident with a match
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4clr_a_match", 32'(if_a.match), 32'd1);
        chk("t4clr_a_cnt", 32'(if_a.match_cnt), 32'd1);
        chk("t4clr_c_cnt", 32'(if_c.match_cnt), 32'd1);
        chk("t4clr_c_sat", 32'(if_c.cnt_sat), 32'd0);
        chk("t4clr_b_match", 32'(if_b.match), 32'd0);
        chk("t4clr_b_cnt", 32'(if_b.match_cnt), 32'd0);

        // Asynchronous reset between edges
        load(4'b1011, 4'b1111);
        run_bits("t5", 4, 16'b1011, 16'b0001, 16'b0001, 16'b0001);
        chk("t5_a_cnt", 32'(if_a.match_cnt), 32'd2);
        rst = 1'b1;
        #1;
        chk("t5_rst_a_match", 32'(if_a.match), 32'd0);
        chk("t5_rst_a_cnt", 32'(if_a.match_cnt), 32'd0);
        chk("t5_rst_c_cnt", 32'(if_c.match_cnt), 32'd0);
        #1;
        rst = 1'b0;
        // Reset pattern 0000 / mask 1111, history must refill from EMPTY
        run_bits("t5r", 4, 16'b0000, 16'b0001, 16'b0001, 16'b0001);

        // x_valid gaps (x=1 on the invalid cycles must be ignored)
        load(4'b1011, 4'b1111);
        cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("t6_g1", 32'(if_a.match), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("t6_g2", 32'(if_a.match), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("t6_g3", 32'(if_a.match), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0); chk("t6_g4", 32'(if_a.match), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("t6_g5", 32'(if_a.match), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("t6_g6", 32'(if_a.match), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("t6_g7", 32'(if_a.match), 32'd1);
        chk("t6_g7_b", 32'(if_b.match), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0); chk("t6_idle", 32'(if_a.match), 32'd0);
        chk("t6_idle_cnt", 32'(if_a.match_cnt), 32'd2);

        // pat_load coincident with the completing bit
        run_bits("t6p", 3, 16'b101, 16'b000, 16'b000, 16'b000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_load_a", 32'(if_a.match), 32'd0);
        chk("t6_load_b", 32'(if_b.match), 32'd0);
        run_bits("t6q", 4, 16'b1011, 16'b0001, 16'b0001, 16'b0001);
        chk("t6_final_cnt", 32'(if_a.match_cnt), 32'd3);

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
